core_arbiter: RTL and testbench



---
 rtl/core_arbiter.sv | 144 ++++++++++++++
 tb/tb_core_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/core_arbiter.sv
// N-to-1 core-protocol arbiter with an in-order ID FIFO that routes responses back to their masters.
// Define CORE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module core_arbiter #(
    parameter int N     = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        m_req,
    output logic [N-1:0]        m_gnt,
    output logic [N-1:0]        m_rvalid,
    input  logic [N-1:0]        m_we,
    input  logic [N*DW/8-1:0]   m_be,
    input  logic [N*AW-1:0]     m_addr,
    input  logic [N*DW-1:0]     m_wdata,
    output logic [DW-1:0]       m_rdata,
    output logic [N-1:0]        m_err,
    output logic                s_req,
    output logic                s_we,
    output logic [DW/8-1:0]     s_be,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    input  logic                s_gnt,
    input  logic                s_rvalid,
    input  logic [DW-1:0]       s_rdata,
    input  logic                s_err,
    output logic                proto_err
);
    localparam int BW = DW / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          proto_err_q;

    logic [IW-1:0] win, cur, head;
    logic          full, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef CORE_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_req[i]) win = IW'(i);
        end
    end
`else
    logic [IW-1:0] rr_q;
    logic [IW:0]   rot;

    // Scan from the far end so the requester closest to rr is the last to write win.
    always_comb begin
        win = '0;
        rot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rot = {1'b0, rr_q} + (IW+1)'(i);
            if (rot >= (IW+1)'(N)) rot = rot - (IW+1)'(N);
            if (m_req[rot[IW-1:0]]) win = rot[IW-1:0];
        end
    end
`endif

    // full is registered-count based, so a same-cycle pop never reopens the request path.
    assign full  = (cnt_q == CW'(DEPTH));
    assign cur   = (state_q == LOCK) ? sel_q : win;
    assign s_req = rst_n && !full && ((state_q == LOCK) || (|m_req));
    assign push  = s_req && s_gnt;
    assign head  = fifo_q[rd_ptr_q];
    assign pop   = rst_n && s_rvalid && (cnt_q != '0);

    assign s_we      = m_we[cur];
    assign s_be      = m_be[cur*BW +: BW];
    assign s_addr    = m_addr[cur*AW +: AW];
    assign s_wdata   = m_wdata[cur*DW +: DW];
    assign m_rdata   = s_rdata;
    assign proto_err = proto_err_q;

    always_comb begin
        m_gnt    = '0;
        m_rvalid = '0;
        m_err    = '0;
        if (push) m_gnt[cur] = 1'b1;
        if (pop) begin
            m_rvalid[head] = 1'b1;
            m_err[head]    = s_err;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: if (s_req && !s_gnt) begin
                state_d = LOCK;
                sel_d   = win;
            end
            LOCK: if (push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
`ifndef CORE_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= cur;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
`ifndef CORE_ARB_FIXED_PRIO_EN
                rr_q             <= (cur == IW'(N - 1)) ? '0 : cur + 1'b1;
`endif
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (s_rvalid && (cnt_q == '0)) proto_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_arbiter.sv
// Directed bench for core_arbiter: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_core_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_req, m_gnt, m_rvalid, m_we, m_err;
    logic [7:0]  m_be;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, proto_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int   gq[$];
    rsp_t rq[$];
    int   mg;
    rsp_t mr;

`ifdef CORE_ARB_FIXED_PRIO_EN
    int rr_seq[4] = '{0, 0, 0, 0};
    int lk2 = 0;
`else
    int rr_seq[4] = '{1, 0, 1, 0};
    int lk2 = 1;
`endif

    core_arbiter #(.N(2), .AW(32), .DW(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic er);
        m_req = req; s_gnt = gnt; s_rvalid = rv; s_rdata = rd; s_err = er;
    endtask

    task automatic exp_r(input int idx, input logic [31:0] d, input logic e);
        rsp_t r;
        r.idx = idx; r.data = d; r.err = e;
        rq.push_back(r);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Master 0: read, addr 0x100; master 1: write, addr 0x200, be 0xC.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_gnt !== 2'b00) begin
                if (gq.size() == 0) chk("unexpected_gnt", {30'b0, m_gnt}, 32'h0);
                else begin
                    mg = gq.pop_front();
                    chk("gnt", {30'b0, m_gnt}, 32'h1 << mg);
                    chk("s_addr", s_addr, (mg == 0) ? 32'h100 : 32'h200);
                    chk("s_wdata", s_wdata, (mg == 0) ? 32'h1111_1111 : 32'h5555_5555);
                    chk("s_be", {28'b0, s_be}, (mg == 0) ? 32'hF : 32'hC);
                    chk("s_we", {31'b0, s_we}, (mg == 0) ? 32'h0 : 32'h1);
                end
            end
            if (m_rvalid !== 2'b00) begin
                if (rq.size() == 0) chk("unexpected_rvalid", {30'b0, m_rvalid}, 32'h0);
                else begin
                    mr = rq.pop_front();
                    chk("rvalid", {30'b0, m_rvalid}, 32'h1 << mr.idx);
                    chk("rdata", m_rdata, mr.data);
                    chk("m_err", {30'b0, m_err}, mr.err ? (32'h1 << mr.idx) : 32'h0);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        m_we    = 2'b10;
        m_be    = {4'hC, 4'hF};
        m_addr  = {32'h200, 32'h100};
        m_wdata = {32'h5555_5555, 32'h1111_1111};
        drv(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
        mid();
        chk("rst_s_req", {31'b0, s_req}, 32'h0);
        chk("rst_m_gnt", {30'b0, m_gnt}, 32'h0);
        chk("rst_m_rvalid", {30'b0, m_rvalid}, 32'h0);
        nxt(); nxt();
        rst_n = 1'b1;
        drv(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        mid();
        chk("rst_proto_err", {31'b0, proto_err}, 32'h0);
        chk("idle_s_req", {31'b0, s_req}, 32'h0);
        nxt();

        // single master read
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0);
        mid(); chk("t1_s_req", {31'b0, s_req}, 32'h1); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0); exp_r(0, 32'hDEADBEEF, 1'b0);
        mid(); chk("t1_m_rvalid1", {31'b0, m_rvalid[1]}, 32'h0); nxt();

        // continuous requests from both, prompt responses
        for (int k = 0; k < 5; k++) begin
            drv((k < 4) ? 2'b11 : 2'b00, k < 4, k > 0, 32'hA000_0000 + k, 1'b0);
            if (k < 4) gq.push_back(rr_seq[k]);
            if (k > 0) exp_r(rr_seq[k-1], 32'hA000_0000 + k, 1'b0);
            mid(); nxt();
        end

        // lock on master 0 while slave stalls
        for (int k = 0; k < 4; k++) begin
            drv((k == 0) ? 2'b01 : 2'b11, k == 3, 1'b0, 32'h0, 1'b0);
            if (k == 3) gq.push_back(0);
            mid();
            chk("lk_s_req", {31'b0, s_req}, 32'h1);
            chk("lk_s_addr", s_addr, 32'h100);
            if (k < 3) chk("lk_no_gnt", {30'b0, m_gnt}, 32'h0);
            nxt();
        end
        drv(2'b11, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(lk2); mid(); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hB000_0000, 1'b0); exp_r(0, 32'hB000_0000, 1'b0); mid(); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hB000_0001, 1'b1); exp_r(lk2, 32'hB000_0001, 1'b1); mid(); nxt();

        // depth limit
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0); mid(); nxt();
        drv(2'b10, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(1); mid(); nxt();
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        mid(); chk("dp_full_s_req", {31'b0, s_req}, 32'h0); chk("dp_full_gnt", {30'b0, m_gnt}, 32'h0); nxt();
        drv(2'b01, 1'b1, 1'b1, 32'hC000_0000, 1'b0); exp_r(0, 32'hC000_0000, 1'b0);
        mid(); chk("dp_pop_s_req", {31'b0, s_req}, 32'h0); chk("dp_pop_gnt", {30'b0, m_gnt}, 32'h0); nxt();
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0);
        mid(); chk("dp_reopen_s_req", {31'b0, s_req}, 32'h1); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hC000_0001, 1'b0); exp_r(1, 32'hC000_0001, 1'b0); mid(); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hC000_0002, 1'b0); exp_r(0, 32'hC000_0002, 1'b0); mid(); nxt();

        // routing with error
        drv(2'b10, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(1); mid(); nxt();
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0); mid(); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hD000_0000, 1'b1); exp_r(1, 32'hD000_0000, 1'b1); mid(); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hD000_0001, 1'b0); exp_r(0, 32'hD000_0001, 1'b0); mid(); nxt();

        // reset with two outstanding, then orphan response
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0); mid(); nxt();
        drv(2'b10, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(1); mid(); nxt();
        rst_n = 1'b0;
        drv(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        mid(); chk("mid_rst_s_req", {31'b0, s_req}, 32'h0); nxt();
        rst_n = 1'b1;
        drv(2'b00, 1'b0, 1'b1, 32'hE000_0000, 1'b0);
        mid();
        chk("orphan_m_rvalid", {30'b0, m_rvalid}, 32'h0);
        chk("orphan_pe_comb", {31'b0, proto_err}, 32'h0);
        nxt();
        drv(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        mid(); chk("pe_set", {31'b0, proto_err}, 32'h1); nxt();
        drv(2'b01, 1'b1, 1'b0, 32'h0, 1'b0); gq.push_back(0);
        mid(); chk("pe_sticky_gnt", {31'b0, proto_err}, 32'h1); nxt();
        drv(2'b00, 1'b0, 1'b1, 32'hE000_0001, 1'b0); exp_r(0, 32'hE000_0001, 1'b0);
        mid(); chk("pe_sticky_rsp", {31'b0, proto_err}, 32'h1); nxt();
        drv(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0; nxt();
        rst_n = 1'b1;
        mid(); chk("pe_cleared", {31'b0, proto_err}, 32'h0); nxt();

        chk("gq_drained", gq.size(), 32'h0);
        chk("rq_drained", rq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
